// File: rtl/addsub_pkg.sv
// Shared types for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/ripple_adder_n.sv
// Combinational N-bit ripple-carry adder built from 1-bit full adders.
// Also exposes the carry into the top bit so the caller can form overflow.
module ripple_adder_n #(
  parameter int unsigned N = 1
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [N:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < N; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end
    co       = c[N];
    c_msb_in = c[N-1];
  end

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle adder/subtractor: consumes WIDTH-bit operands DIGIT bits per clock,
// then holds sum and flags in DONE until the consumer accepts them.
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("digit_serial_addsub: WIDTH must be a multiple of DIGIT");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [DIGIT-1:0]       dig_s;
  logic                   dig_co;
  logic                   dig_cm;
  logic                   last_dig;
  logic                   is_sub;
  logic [WIDTH+DIGIT-1:0] a_cat;
  logic [WIDTH-1:0]       a_shift;

  ripple_adder_n #(
    .N(DIGIT)
  ) u_adder (
    .x        (a_q[DIGIT-1:0]),
    .y        (b_q[DIGIT-1:0]),
    .ci       (carry_q),
    .s        (dig_s),
    .co       (dig_co),
    .c_msb_in (dig_cm)
  );

  assign last_dig = (cnt_q == CntW'(NDIG - 1));
  assign is_sub   = (op_e'(op) == OP_SUB);

  // A doubles as the result shifter: digit sums enter at the top as operand bits leave the bottom.
  assign a_cat   = {dig_s, a_q};
  assign a_shift = a_cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid && in_ready) state_d = S_RUN;
      S_RUN:   if (last_dig) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = is_sub ? ~b : b;
          carry_d = is_sub ? ~cin : cin;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        a_d     = a_shift;
        b_d     = b_q >> DIGIT;
        carry_d = dig_co;
        cnt_d   = cnt_q + 1'b1;
        if (last_dig) begin
          sum_d  = a_shift;
          cout_d = dig_co;
          ovf_d  = dig_cm ^ dig_co;
          zero_d = (a_shift == '0);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
    zero      = zero_q;
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed and random bench for digit_serial_addsub across eight WIDTH/DIGIT configurations.
module tb_digit_serial_addsub;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_valid, out_ready, cin, op;
  wire  [7:0]  in_ready, out_valid, cout, ovf, zero;
  logic [15:0] a_v [8];
  logic [15:0] b_v [8];
  wire  [15:0] sum_v [8];

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // k = 0..3 -> WIDTH 8, k = 4..7 -> WIDTH 16; DIGIT = 1, 2, 4, 8 cycling.
  for (genvar k = 0; k < 8; k++) begin : g_dut
    localparam int unsigned W = (k < 4) ? 8 : 16;
    localparam int unsigned D = 1 << (k % 4);
    logic [W-1:0] sum_w;

    digit_serial_addsub #(
      .WIDTH(W),
      .DIGIT(D)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .a         (a_v[k][W-1:0]),
      .b         (b_v[k][W-1:0]),
      .cin       (cin[k]),
      .op        (op[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .sum       (sum_w),
      .cout      (cout[k]),
      .ovf       (ovf[k]),
      .zero      (zero[k])
    );

    assign sum_v[k] = 16'(sum_w);
  end

  function automatic int width_of(input int k);
    return (k < 4) ? 8 : 16;
  endfunction

  function automatic int ndig_of(input int k);
    return width_of(k) / (1 << (k % 4));
  endfunction

  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic o);
    exp_t        r;
    logic [15:0] mask, aa, bb;
    logic [16:0] full;
    mask   = (w == 16) ? 16'hFFFF : 16'h00FF;
    aa     = a & mask;
    bb     = (o ? ~b : b) & mask;
    full   = {1'b0, aa} + {1'b0, bb} + {16'b0, (o ? ~ci : ci)};
    r.sum  = full[15:0] & mask;
    r.cout = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
    r.zero = (r.sum == 16'h0000);
    return r;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] expv);
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble(input int k);
    in_valid[k] = 1'($urandom_range(0, 1));
    a_v[k]      = 16'($urandom);
    b_v[k]      = 16'($urandom);
    cin[k]      = 1'($urandom_range(0, 1));
    op[k]       = 1'($urandom_range(0, 1));
  endtask

  // One full transaction: accept, count latency, compare against the scoreboard,
  // hold in DONE for 'hold' cycles with busy inputs, then release.
  task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic o, input int hold);
    exp_t e;
    int   lat;
    vectors++;
    chk("in_ready_idle", k, 32'(in_ready[k]), 32'd1);
    in_valid[k] = 1'b1;
    a_v[k]      = a;
    b_v[k]      = b;
    cin[k]      = ci;
    op[k]       = o;
    sb_q.push_back(model(width_of(k), a, b, ci, o));
    tick();
    scramble(k);
    out_ready[k] = 1'($urandom_range(0, 1));
    chk("in_ready_run", k, 32'(in_ready[k]), 32'd0);
    lat = 0;
    while (!out_valid[k] && lat < 40) begin
      tick();
      lat++;
      scramble(k);
    end
    chk("latency", k, 32'(lat), 32'(ndig_of(k)));
    e = sb_q.pop_front();
    chk("out_valid", k, 32'(out_valid[k]), 32'd1);
    chk("sum", k, 32'(sum_v[k]), 32'(e.sum));
    chk("cout", k, 32'(cout[k]), 32'(e.cout));
    chk("ovf", k, 32'(ovf[k]), 32'(e.ovf));
    chk("zero", k, 32'(zero[k]), 32'(e.zero));
    out_ready[k] = 1'b0;
    repeat (hold) begin
      tick();
      scramble(k);
      chk("hold_valid", k, 32'(out_valid[k]), 32'd1);
      chk("hold_in_ready", k, 32'(in_ready[k]), 32'd0);
      chk("hold_sum", k, 32'(sum_v[k]), 32'(e.sum));
      chk("hold_flags", k, {29'd0, cout[k], ovf[k], zero[k]}, {29'd0, e.cout, e.ovf, e.zero});
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    chk("release_valid", k, 32'(out_valid[k]), 32'd0);
    chk("release_in_ready", k, 32'(in_ready[k]), 32'd1);
    chk("release_sum", k, 32'(sum_v[k]), 32'(e.sum));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    cin       = '0;
    op        = '0;
    for (int k = 0; k < 8; k++) begin
      a_v[k] = '0;
      b_v[k] = '0;
    end
    tick();
    tick();
    chk("rst_in_ready", 0, 32'(in_ready), 32'h00);
    chk("rst_out_valid", 0, 32'(out_valid), 32'h00);
    chk("rst_flags", 0, {8'd0, cout, ovf, zero}, 32'd0);
    for (int k = 0; k < 8; k++) chk("rst_sum", k, 32'(sum_v[k]), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 0, 32'(in_ready), 32'hFF);

    // Directed cases, WIDTH 8 DIGIT 1 then WIDTH 8 DIGIT 4.
    do_op(0, 16'h7F, 16'h01, 1'b0, 1'b0, 0);
    chk("tp_7f_plus_1", 0, {20'd0, sum_v[0][7:0], cout[0], ovf[0], zero[0], 1'b0},
        {20'd0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0});
    do_op(0, 16'hFF, 16'h01, 1'b0, 1'b0, 0);
    do_op(0, 16'h80, 16'h01, 1'b0, 1'b1, 0);
    do_op(2, 16'h3C, 16'h0A, 1'b1, 1'b0, 0);
    chk("tp_3c_plus_0a_c", 2, 32'(sum_v[2]), 32'h47);
    do_op(2, 16'h05, 16'h05, 1'b0, 1'b1, 0);

    // Backpressure: five stalled cycles in DONE with toggling inputs.
    do_op(0, 16'h5A, 16'hC3, 1'b1, 1'b0, 5);

    // Reset during RUN cycle 3 must abort with cleared outputs.
    in_valid[0] = 1'b1;
    a_v[0]      = 16'h33;
    b_v[0]      = 16'h44;
    cin[0]      = 1'b0;
    op[0]       = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready_low", 0, 32'(in_ready[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_mid_out_valid", 0, 32'(out_valid[0]), 32'd0);
    chk("rst_mid_sum", 0, 32'(sum_v[0]), 32'd0);
    chk("rst_mid_flags", 0, {29'd0, cout[0], ovf[0], zero[0]}, 32'd0);
    chk("rst_mid_in_ready", 0, 32'(in_ready[0]), 32'd1);
    repeat (10) begin
      tick();
      chk("rst_mid_no_result", 0, 32'(out_valid[0]), 32'd0);
    end
    do_op(0, 16'h10, 16'h20, 1'b0, 1'b1, 0);
    chk("tp_10_minus_20", 0, {23'd0, sum_v[0][7:0], cout[0]}, {23'd0, 8'hF0, 1'b0});

    // Random sweep across all configurations.
    for (int i = 0; i < 1000; i++) begin
      do_op($urandom_range(0, 7), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
- Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock.
- Generalises the team's 1-bit full adder: width, digit size, subtract mode, carry-in, flags and valid/ready handshakes.
- Sits between operand registers and the result/flag bus of the lab ALU datapath, where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits.
- DIGIT, 1, bits processed per cycle. WIDTH % DIGIT must equal 0; otherwise $error at elaboration.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- cin  input  1  carry-in (ADD) or borrow-in (SUB).
- op  input  1  0 = ADD (a+b+cin), 1 = SUB (a-b-cin).
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of MSB (SUB: 1 = no borrow).
- ovf  output  1  two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset (rst_n low at a rising edge): state IDLE; sum, cout, ovf, zero, out_valid = 0; digit counter and carry register = 0. in_ready is 0 while rst_n is low.
- Reset mid-operation aborts the operation. No partial result is ever presented.
- NDIG = WIDTH/DIGIT.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture a into shift register A and (op ? ~b : b) into shift register B.
  - Set carry = op ? ~cin : cin; clear counter; go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle add the low DIGIT bits of A and B plus carry, using the sub-module.
  - Shift the digit sum into the result register from the MSB side. Shift A and B right by DIGIT.
  - Update carry; increment the counter.
  - On the cycle with counter == NDIG-1, latch cout = final carry and ovf = (carry into MSB) ^ (carry out of MSB).
  - Go to DONE.
- DONE:
  - out_valid = 1. sum, cout, ovf and zero are held stable.
  - zero is computed from the final sum.
  - On out_ready, go to IDLE and clear out_valid. The registered sum and flags remain unchanged until the next completion.
- Latency: out_valid rises exactly NDIG clock edges after the accepting edge. Throughput is one operation per NDIG+2 cycles with out_ready tied high.
- in_valid is ignored outside IDLE. Operands are not required to stay stable after acceptance.
- out_ready outside DONE has no effect.
- DIGIT == WIDTH is legal: RUN lasts one cycle.
- Arithmetic is modulo 2^WIDTH. Flags follow standard two's-complement semantics.

Decomposition:
- Package addsub_pkg:
  - op_e enum {OP_ADD = 1'b0, OP_SUB = 1'b1}.
  - state_e enum {S_IDLE, S_RUN, S_DONE}.
- Sub-module ripple_adder_n (parameter N = DIGIT):
  - Purely combinational chain of N 1-bit full adders.
  - Inputs: x[N], y[N], ci. Outputs: s[N], co, c_msb_in (carry into bit N-1).
- Top level holds the FSM, counter, shift registers, carry register and flag logic.

Test Plan:
- WIDTH=8, DIGIT=1, ADD a=0x7F, b=0x01, cin=0 -> after 8 edges: out_valid=1, sum=0x80, cout=0, ovf=1, zero=0.
- WIDTH=8, DIGIT=1, ADD a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0, zero=1. SUB a=0x80, b=0x01, cin=0 -> sum=0x7F, cout=1, ovf=1.
- WIDTH=8, DIGIT=4, ADD a=0x3C, b=0x0A, cin=1 -> out_valid after 2 edges, sum=0x47, cout=0, ovf=0. SUB a=0x05, b=0x05, cin=0 -> sum=0x00, cout=1, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> sum and flags stable, in_ready=0, no new capture. Then out_ready=1 -> IDLE next edge.
- Reset mid-RUN: drop rst_n for 1 edge at RUN cycle 3 -> all outputs 0, state IDLE. The next operation, SUB 0x10 - 0x20 (cin=0), gives sum=0xF0, cout=0.
- Random sweep over WIDTH∈{8,16} and DIGIT∈{1,2,4,8}, 1000 ops with random out_ready -> sum, cout, ovf and zero match a reference model. Latency equals NDIG on every operation.
